// File: rtl/randomlogic_2.sv
// randomlogic_2: registered three-way operand selector.
// Out is loaded each clock with A, B or C. Cond1 has the highest priority.
// B is taken when Cond2 is set and C is below THRESH. Otherwise C is taken.
// The B path is pre-qualified with !Cond1, so the late C < THRESH compare
// feeds the first and shortest decode level.
module randomlogic_2 #(
   parameter int WIDTH  = 8,
   parameter int THRESH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [WIDTH-1:0] C,
   input  logic             Cond1,
   input  logic             Cond2,
   output logic [WIDTH-1:0] Out
);

   localparam logic [WIDTH-1:0] LP_THRESH = WIDTH'(THRESH);

   logic             w_cond_b;
   logic             w_c_lt;
   logic             w_sel_b;
   logic [WIDTH-1:0] w_next;
   logic [WIDTH-1:0] r_out;

   // Decode the select and pick the next operand; the B term is checked first because Cond1 is already folded out of it.
   always_comb begin
      w_cond_b = Cond2 & ~Cond1;
      w_c_lt   = (C < LP_THRESH);
      w_sel_b  = w_cond_b & w_c_lt;
      w_next   = C;
      if (w_sel_b) begin
         w_next = B;
      end else if (Cond1) begin
         w_next = A;
      end
   end

   // Output register: sync reset clears it, otherwise it captures the selected operand.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out <= '0;
      end else begin
         r_out <= w_next;
      end
   end

   assign Out = r_out;

endmodule

// File: tb/tb_randomlogic_2.sv
// Testbench for randomlogic_2.
// Applies a directed vector table and then random traffic checked against a reference priority chain.
module tb_randomlogic_2;

   localparam int WIDTH  = 8;
   localparam int THRESH = 8;

   logic             clk;
   logic             rst;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [WIDTH-1:0] C;
   logic             Cond1;
   logic             Cond2;
   logic [WIDTH-1:0] Out;

   int checks;
   int errors;

   typedef struct {
      logic             rst;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] c;
      logic             c1;
      logic             c2;
      logic [WIDTH-1:0] exp;
      string            name;
   } vec_t;

   vec_t vecs[12];

   randomlogic_2 #(.WIDTH(WIDTH), .THRESH(THRESH)) dut (
      .clk   (clk),
      .rst   (rst),
      .A     (A),
      .B     (B),
      .C     (C),
      .Cond1 (Cond1),
      .Cond2 (Cond2),
      .Out   (Out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [WIDTH-1:0] ref_out(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                input logic [WIDTH-1:0] c, input logic c1, input logic c2);
      if (c1) return a;
      if (c2 && (int'(c) < THRESH)) return b;
      return c;
   endfunction

   task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic set_vec(input int idx, input logic r, input int a, input int b, input int c,
                          input logic c1, input logic c2, input int e, input string nm);
      vecs[idx].rst  = r;
      vecs[idx].a    = WIDTH'(a);
      vecs[idx].b    = WIDTH'(b);
      vecs[idx].c    = WIDTH'(c);
      vecs[idx].c1   = c1;
      vecs[idx].c2   = c2;
      vecs[idx].exp  = WIDTH'(e);
      vecs[idx].name = nm;
   endtask

   initial begin
      logic [WIDTH-1:0] prev;
      logic [WIDTH-1:0] exp;
      checks = 0;
      errors = 0;
      rst = 1'b1; A = '0; B = '0; C = '0; Cond1 = 1'b0; Cond2 = 1'b0;

      set_vec(0,  1'b1,  55, 66,  77, 1'b1, 1'b0,   0, "reset_edge1");
      set_vec(1,  1'b1,   1,  2,   3, 1'b0, 1'b1,   0, "reset_edge2");
      set_vec(2,  1'b0,   0,  0,  19, 1'b0, 1'b0,  19, "first_after_reset");
      set_vec(3,  1'b0, 123, 32,  19, 1'b0, 1'b0,  19, "default_c");
      set_vec(4,  1'b0,  13, 42,  79, 1'b1, 1'b0,  13, "select_a");
      set_vec(5,  1'b0,   7,  6,   4, 1'b0, 1'b1,   6, "select_b_c4");
      set_vec(6,  1'b0,   7,  6,   8, 1'b0, 1'b1,   8, "c_eq_thresh");
      set_vec(7,  1'b0,   7,  6,   7, 1'b0, 1'b1,   6, "c_thresh_m1");
      set_vec(8,  1'b0,   7,  6,   4, 1'b1, 1'b1,   7, "cond1_priority");
      set_vec(9,  1'b1,   7,  6,   4, 1'b1, 1'b1,   0, "reset_over_cond1");
      set_vec(10, 1'b0,   9,  6,   0, 1'b0, 1'b1,   6, "c_zero_b");
      set_vec(11, 1'b0,   9,  6, 255, 1'b0, 1'b1, 255, "c_max_unsigned");

      // Directed table: drive on the falling edge, check just after the rising edge.
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         rst = vecs[i].rst; A = vecs[i].a; B = vecs[i].b; C = vecs[i].c;
         Cond1 = vecs[i].c1; Cond2 = vecs[i].c2;
         @(posedge clk);
         #1;
         check(vecs[i].name, Out, vecs[i].exp);
      end

      // Hold check: with no edge, changing inputs must not move Out.
      prev = Out;
      @(negedge clk);
      rst = 1'b0; A = 8'd200; B = 8'd3; C = 8'd2; Cond1 = 1'b0; Cond2 = 1'b1;
      #2;
      check("hold_directed", Out, prev);
      @(posedge clk);
      #1;
      check("after_hold", Out, 8'd3);

      // Random traffic with a one-clock delayed reference and a between-edge stability check.
      for (int i = 0; i < 1000; i++) begin
         prev = Out;
         @(negedge clk);
         rst   = 1'b0;
         A     = WIDTH'($urandom);
         B     = WIDTH'($urandom);
         C     = ($urandom_range(0, 1) == 1) ? WIDTH'($urandom_range(0, 15)) : WIDTH'($urandom);
         Cond1 = 1'($urandom_range(0, 1));
         Cond2 = 1'($urandom_range(0, 1));
         exp   = ref_out(A, B, C, Cond1, Cond2);
         #2;
         check("rand_hold", Out, prev);
         @(posedge clk);
         #1;
         check("rand_out", Out, exp);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
